// File: rtl/pixel_pkg.sv
// Shared pixel types and raster dimensions for the line window front end.
// Also holds the centre-row index helper used by the window buffer.
package pixel_pkg;

    typedef logic [15:0] rgb565_t;

    localparam int HRES_DEFAULT = 320;
    localparam int VRES_DEFAULT = 180;
    localparam int HCOUNT_W     = 11;
    localparam int VCOUNT_W     = 10;
    localparam int NLINES       = 4;

    // The window centre sits two lines behind the incoming row; rows 0 and 1
    // map back into the tail of the previous frame.
    function automatic logic [VCOUNT_W-1:0] centre_row(input logic [VCOUNT_W-1:0] v,
                                                       input int vres);
        if (v >= VCOUNT_W'(2))
            return v - VCOUNT_W'(2);
        else
            return v + VCOUNT_W'(vres - 2);
    endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM: one write port, one read port, two-cycle read.
// Only the read pipeline registers are reset; stored pixels are left untouched.
module line_ram
    import pixel_pkg::*;
#(
    parameter int DEPTH  = HRES_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  rgb565_t           wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output rgb565_t           rdata
);

    rgb565_t mem [DEPTH];
    rgb565_t q1;
    logic    re_d;

    always_ff @(posedge clk_in) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Both read stages are enabled by the request, so rdata holds across gaps.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            re_d  <= 1'b0;
            q1    <= '0;
            rdata <= '0;
        end else begin
            re_d <= re;
            if (re)
                q1 <= mem[raddr];
            if (re_d)
                rdata <= q1;
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Rotating four-line buffer that presents three vertically adjacent pixels
// per column to the 3x3 convolution stage, two cycles after each accepted pixel.
module line_window_buffer
    import pixel_pkg::*;
#(
    parameter int HRES = HRES_DEFAULT,
    parameter int VRES = VRES_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  rgb565_t                  pixel_data_in,
    input  logic [HCOUNT_W-1:0]      hcount_in,
    input  logic [VCOUNT_W-1:0]      vcount_in,
    input  logic                     data_valid_in,
    output logic [2:0][15:0]         line_buffer_out,
    output logic [HCOUNT_W-1:0]      hcount_out,
    output logic [VCOUNT_W-1:0]      vcount_out,
    output logic                     data_valid_out
);

    localparam int ADDR_W = $clog2(HRES);

    logic                    accept;
    logic                    line_end;
    logic [1:0]              wr_sel;
    logic [NLINES-1:0]       we;
    logic [NLINES-1:0]       re;
    logic [NLINES-1:0][15:0] rd;

    logic                    v1, v2;
    logic [HCOUNT_W-1:0]     h1, h2;
    logic [VCOUNT_W-1:0]     vc1, vc2;
    logic [1:0]              sel1, sel2;

    assign accept   = data_valid_in && !rst_in && (hcount_in < HCOUNT_W'(HRES));
    assign line_end = accept && (hcount_in == HCOUNT_W'(HRES - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in)
            wr_sel <= 2'd0;
        else if (line_end)
            wr_sel <= wr_sel + 2'd1;
    end

    // The RAM being written is never read, so read/write collisions cannot occur.
    always_comb begin
        we = '0;
        re = '0;
        for (int i = 0; i < NLINES; i++) begin
            we[i] = accept && (wr_sel == 2'(i));
            re[i] = accept && (wr_sel != 2'(i));
        end
    end

    for (genvar g = 0; g < NLINES; g++) begin : g_ram
        line_ram #(.DEPTH(HRES), .ADDR_W(ADDR_W)) u_ram (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .we     (we[g]),
            .waddr  (hcount_in[ADDR_W-1:0]),
            .wdata  (pixel_data_in),
            .re     (re[g]),
            .raddr  (hcount_in[ADDR_W-1:0]),
            .rdata  (rd[g])
        );
    end

    // Side-band pipeline mirrors the two RAM read stages.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            h1   <= '0;
            h2   <= '0;
            vc1  <= '0;
            vc2  <= '0;
            sel1 <= 2'd0;
            sel2 <= 2'd0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept) begin
                h1   <= hcount_in;
                vc1  <= centre_row(vcount_in, VRES);
                sel1 <= wr_sel;
            end
            if (v1) begin
                h2   <= h1;
                vc2  <= vc1;
                sel2 <= sel1;
            end
        end
    end

    assign hcount_out     = h2;
    assign vcount_out     = vc2;
    assign data_valid_out = v2;

    // Oldest line sits just after the write slot, newest just before it.
    always_comb begin
        line_buffer_out = '0;
        for (int k = 0; k < 3; k++)
            line_buffer_out[k] = rd[sel2 + 2'(k + 1)];
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench: directed raster scenarios plus randomized frames,
// compared against a line-history reference model.
module tb_line_window_buffer;

    localparam int HRES = 8;
    localparam int VRES = 6;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic [15:0]      pixel_data_in = '0;
    logic [10:0]      hcount_in = '0;
    logic [9:0]       vcount_in = '0;
    logic             data_valid_in = 1'b0;
    logic [2:0][15:0] line_buffer_out;
    logic [10:0]      hcount_out;
    logic [9:0]       vcount_out;
    logic             data_valid_out;

    always #5 clk_in = ~clk_in;

    line_window_buffer #(.HRES(HRES), .VRES(VRES)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .pixel_data_in   (pixel_data_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .data_valid_in   (data_valid_in),
        .line_buffer_out (line_buffer_out),
        .hcount_out      (hcount_out),
        .vcount_out      (vcount_out),
        .data_valid_out  (data_valid_out)
    );

    typedef struct {
        bit               v;
        int               h;
        int               vc;
        logic [2:0][15:0] row;
        logic [2:0]       kn;
    } exp_t;

    // hist[0] = line being written, hist[1] = previous line, ... hist[3] = three back
    logic [15:0] hist [4][HRES];
    bit          hk   [4][HRES];

    exp_t             pipe0, pipe1;
    logic             hv;
    int               hh, hvc;
    logic [2:0][15:0] hrow;
    logic [2:0]       hkn;
    bit               rst_prev = 1'b1;
    bit               inited   = 1'b0;
    int               passed   = 0;
    int               total    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic forget_all();
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < HRES; c++)
                hk[l][c] = 1'b0;
    endtask

    task automatic step(input bit rst, input bit vld, input int h, input int v,
                        input logic [15:0] pix);
        exp_t e;
        @(posedge clk_in);
        #1;
        if (rst_prev) begin
            hv = 1'b0; hh = 0; hvc = 0; hrow = '0; hkn = '1;
            pipe0.v = 1'b0; pipe1.v = 1'b0;
            inited = 1'b1;
        end else if (pipe1.v) begin
            hv = 1'b1; hh = pipe1.h; hvc = pipe1.vc; hrow = pipe1.row; hkn = pipe1.kn;
        end else begin
            hv = 1'b0;
        end
        if (inited) begin
            chk("valid", 32'(data_valid_out), 32'(hv));
            chk("hcount", 32'(hcount_out), 32'(hh));
            chk("vcount", 32'(vcount_out), 32'(hvc));
            for (int k = 0; k < 3; k++)
                if (hkn[k]) chk($sformatf("row%0d", k), 32'(line_buffer_out[k]), 32'(hrow[k]));
        end
        pipe1 = pipe0;

        rst_in        = rst;
        data_valid_in = vld;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        pixel_data_in = pix;

        e.v = !rst && vld && (h < HRES);
        e.h = h; e.vc = 0; e.row = '0; e.kn = '0;
        if (e.v) begin
            e.vc = (v >= 2) ? v - 2 : v + VRES - 2;
            for (int k = 0; k < 3; k++) begin
                e.row[k] = hist[3 - k][h];
                e.kn[k]  = hk[3 - k][h];
            end
            hist[0][h] = pix;
            hk[0][h]   = 1'b1;
            if (h == HRES - 1) begin
                for (int l = 3; l > 0; l--)
                    for (int c = 0; c < HRES; c++) begin
                        hist[l][c] = hist[l - 1][c];
                        hk[l][c]   = hk[l - 1][c];
                    end
                for (int c = 0; c < HRES; c++)
                    hk[0][c] = 1'b0;
            end
        end
        if (rst) forget_all();
        pipe0    = e;
        rst_prev = rst;
    endtask

    function automatic logic [15:0] dpix(input int v, input int h);
        return {5'(v), 6'(h), 5'd0};
    endfunction

    task automatic feed(input int v, input int h_lo, input int h_hi);
        for (int h = h_lo; h <= h_hi; h++)
            step(1'b0, 1'b1, h, v, dpix(v, h));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 0, 0, 16'h0);
    endtask

    initial begin
        forget_all();
        pipe0.v = 1'b0;
        pipe1.v = 1'b0;

        // reset held two cycles, outputs must read zero
        step(1'b1, 1'b0, 0, 0, 16'h0);
        step(1'b0, 1'b0, 0, 0, 16'h0);
        idle(2);

        // fill lines 0..3 with a gap mid line 3, then into line 4 and 5
        for (int v = 0; v < 3; v++) feed(v, 0, HRES - 1);
        feed(3, 0, 3);
        idle(4);
        feed(3, 4, HRES - 1);
        feed(4, 0, HRES - 1);
        feed(5, 0, HRES - 1);

        // next frame: wrapped vcount and an out-of-range column
        feed(0, 0, HRES - 1);
        feed(1, 0, 2);
        step(1'b0, 1'b1, 9, 1, 16'hBEEF);
        feed(1, 3, HRES - 1);
        feed(2, 0, 3);

        // reset right after accepting v=2,h=3, then refill from line 0
        step(1'b1, 1'b0, 0, 0, 16'h0);
        step(1'b0, 1'b0, 0, 0, 16'h0);
        for (int v = 0; v < 4; v++) feed(v, 0, HRES - 1);
        idle(3);

        // randomized frames with gaps and ignored columns
        for (int f = 0; f < 3; f++) begin
            for (int v = 0; v < VRES; v++)
                for (int h = 0; h < HRES; h++) begin
                    for (int t = 0; t < 3; t++) begin
                        if ($urandom_range(3) != 0) break;
                        if ($urandom_range(1) == 0)
                            step(1'b0, 1'b0, h, v, 16'($urandom));
                        else
                            step(1'b0, 1'b1, HRES + int'($urandom_range(0, 20)), v, 16'($urandom));
                    end
                    step(1'b0, 1'b1, h, v, 16'($urandom));
                end
            if (f == 1) step(1'b1, 1'b1, 0, 0, 16'($urandom));
        end
        idle(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
